// File: rtl/decode_out_buffer_if.sv
// Bundle bus between LC3 decode, the decode output buffer and execute.
// A bundle moves on a rising edge where valid & ready & enable_decode & ~flush;
// in_ready depends only on occupancy, and the producer holds valid and data until accepted.
interface decode_out_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int E_WIDTH    = 6,
  parameter int W_WIDTH    = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [E_WIDTH-1:0]    E_Control_in;
  logic                  Mem_Control_in;
  logic [W_WIDTH-1:0]    W_Control_in;
  logic [DATA_WIDTH-1:0] IR_in;
  logic [DATA_WIDTH-1:0] npc_in;

  logic                  out_valid;
  logic                  out_ready;
  logic [E_WIDTH-1:0]    E_Control;
  logic                  Mem_Control;
  logic [W_WIDTH-1:0]    W_Control;
  logic [DATA_WIDTH-1:0] IR;
  logic [DATA_WIDTH-1:0] npc_out;

  modport master (
    output in_valid, E_Control_in, Mem_Control_in, W_Control_in, IR_in, npc_in, out_ready,
    input  in_ready, out_valid, E_Control, Mem_Control, W_Control, IR, npc_out
  );

  modport slave (
    input  in_valid, E_Control_in, Mem_Control_in, W_Control_in, IR_in, npc_in, out_ready,
    output in_ready, out_valid, E_Control, Mem_Control, W_Control, IR, npc_out
  );
endinterface

// File: rtl/decode_out_buffer.sv
// Elastic FIFO between LC3 decode and execute; shows an all-zero NOP bundle when empty.
module decode_out_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int E_WIDTH    = 6,
  parameter int W_WIDTH    = 2,
  parameter int DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_decode,
  input  logic                         flush,
  decode_out_buffer_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [E_WIDTH-1:0]    e_ctl;
    logic                  mem_ctl;
    logic [W_WIDTH-1:0]    w_ctl;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] npc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);

  assign push = enable_decode & bus.in_valid  & bus.in_ready  & ~flush;
  assign pop  = enable_decode & bus.out_valid & bus.out_ready & ~flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (enable_decode) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{e_ctl:   bus.E_Control_in,
                       mem_ctl: bus.Mem_Control_in,
                       w_ctl:   bus.W_Control_in,
                       ir:      bus.IR_in,
                       npc:     bus.npc_in};
    end
  end

  assign head = bus.out_valid ? mem[rd_ptr] : '0;

  assign bus.E_Control   = head.e_ctl;
  assign bus.Mem_Control = head.mem_ctl;
  assign bus.W_Control   = head.w_ctl;
  assign bus.IR          = head.ir;
  assign bus.npc_out     = head.npc;
endmodule

// File: tb/tb_decode_out_buffer.sv
// Directed bench for decode_out_buffer with a queue scoreboard of expected bundles.
module tb_decode_out_buffer;
  localparam int DATA_WIDTH = 16;
  localparam int E_WIDTH    = 6;
  localparam int W_WIDTH    = 2;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH+1);
  localparam int BW         = E_WIDTH + 1 + W_WIDTH + 2*DATA_WIDTH;

  logic          clock;
  logic          reset;
  logic          enable_decode;
  logic          flush;
  logic [CW-1:0] count;

  decode_out_buffer_if #(.DATA_WIDTH(DATA_WIDTH), .E_WIDTH(E_WIDTH), .W_WIDTH(W_WIDTH)) bus ();

  decode_out_buffer #(
    .DATA_WIDTH(DATA_WIDTH), .E_WIDTH(E_WIDTH), .W_WIDTH(W_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .flush         (flush),
    .bus           (bus.slave),
    .count         (count)
  );

  logic [BW-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] head_bits();
    return {bus.E_Control, bus.Mem_Control, bus.W_Control, bus.IR, bus.npc_out};
  endfunction

  function automatic logic [BW-1:0] drive_bits();
    return {bus.E_Control_in, bus.Mem_Control_in, bus.W_Control_in, bus.IR_in, bus.npc_in};
  endfunction

  task automatic set_bundle(input logic [DATA_WIDTH-1:0] ir, input logic [DATA_WIDTH-1:0] npc);
    bus.E_Control_in   = E_WIDTH'($urandom_range(0, (1 << E_WIDTH) - 1));
    bus.Mem_Control_in = 1'($urandom_range(0, 1));
    bus.W_Control_in   = W_WIDTH'($urandom_range(0, (1 << W_WIDTH) - 1));
    bus.IR_in          = ir;
    bus.npc_in         = npc;
  endtask

  // Check occupancy/head against the scoreboard, apply the model's push/pop, advance one edge.
  task automatic cycle();
    bit push_m;
    bit pop_m;
    logic [BW-1:0] exp_head;
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() != DEPTH));
    if (exp_q.size() == 0) chk("nop_head", 64'(head_bits()), 64'd0);
    push_m = 1'b0;
    pop_m  = 1'b0;
    if (enable_decode && !flush) begin
      pop_m  = bus.out_ready && (exp_q.size() != 0);
      push_m = bus.in_valid && (exp_q.size() != DEPTH);
    end
    if (exp_q.size() != 0) begin
      if (pop_m) begin
        exp_head = exp_q.pop_front();
        chk("pop_head", 64'(head_bits()), 64'(exp_head));
      end else begin
        chk("hold_head", 64'(head_bits()), 64'(exp_q[0]));
      end
    end
    if (enable_decode && flush) exp_q.delete();
    if (push_m) exp_q.push_back(drive_bits());
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b0;
    enable_decode  = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    set_bundle(16'h0, 16'h0);

    // reset / idle
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ir", 64'(bus.IR), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    reset         = 1'b1;
    enable_decode = 1'b1;
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_w_control", 64'(bus.W_Control), 64'd0);
    cycle();

    // fill then drain
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_bundle(16'h1000 + 16'(i), 16'h3000 + 16'(i));
      cycle();
    end
    bus.in_valid = 1'b0;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_ir", 64'(bus.IR), 64'(16'h1000 + 16'(i)));
      chk("drain_npc", 64'(bus.npc_out), 64'(16'h3000 + 16'(i)));
      cycle();
    end
    chk("drained_out_valid", 64'(bus.out_valid), 64'd0);

    // streaming, 20 bundles with push and pop every cycle
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_bundle(16'h2000 + 16'(i), 16'(i));
      if (i > 0) begin
        chk("stream_count", 64'(count), 64'd1);
        chk("stream_ir", 64'(bus.IR), 64'(16'h2000 + 16'(i - 1)));
      end
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("stream_empty", 64'(bus.out_valid), 64'd0);

    // full plus simultaneous pop
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_bundle(16'h5000 + 16'(i), 16'h5100 + 16'(i));
      cycle();
    end
    set_bundle(16'h5004, 16'h5104);
    bus.out_ready = 1'b1;
    chk("fullpop_in_ready", 64'(bus.in_ready), 64'd0);
    cycle();
    chk("fullpop_count", 64'(count), 64'd3);
    bus.out_ready = 1'b0;
    cycle();
    chk("fullpop_accept", 64'(count), 64'd4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    chk("fullpop_empty", 64'(count), 64'd0);

    // flush with a push and pop in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_bundle(16'h6000 + 16'(i), 16'h6100 + 16'(i));
      cycle();
    end
    set_bundle(16'h6003, 16'h6103);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    cycle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    cycle();

    // freeze at count 2
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_bundle(16'h4001, 16'h4101);
    cycle();
    set_bundle(16'h4002, 16'h4102);
    cycle();
    enable_decode = 1'b0;
    bus.out_ready = 1'b1;
    set_bundle(16'h4003, 16'h4103);
    for (int i = 0; i < 5; i++) begin
      chk("freeze_count", 64'(count), 64'd2);
      chk("freeze_ir", 64'(bus.IR), 64'h4001);
      cycle();
    end

    // asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_ir", 64'(bus.IR), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    @(posedge clock);
    #1;
    reset         = 1'b1;
    enable_decode = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cycle();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // one bundle through after reset
    bus.in_valid = 1'b1;
    set_bundle(16'h7001, 16'h7101);
    cycle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("post_rst_ir", 64'(bus.IR), 64'h7001);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
